// File: rtl/sec_mask_pkg.sv
// Shared state encoding and sizing helpers for the iterative masked
// Boolean-to-arithmetic converter.
package sec_mask_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_AND0,
        ST_LEVEL,
        ST_SUM,
        ST_REFRESH,
        ST_FOLD,
        ST_DONE
    } state_e;

    function automatic int calc_logk(input int k);
        return $clog2(k);
    endfunction

    function automatic int calc_rnd_w(input int n);
        return n * (n - 1);
    endfunction

    // Bit offset of share (or random word) i in a flat bus of k-bit words.
    function automatic int share_lo(input int i, input int k);
        return i * k;
    endfunction

    // Random word owned by the share pair i < j in an n-share DOM AND.
    function automatic int pair_idx(input int i, input int j, input int n);
        return i * n - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

endpackage

// File: rtl/sec_and_dom.sv
// N-share DOM-indep AND with one register stage: q <= c ^ (mul ? a&b : 0).
// The c input lets the caller fold an XOR accumulation into the same register.
module sec_and_dom
    import sec_mask_pkg::*;
#(
    parameter int K_WIDTH  = 32,
    parameter int N_SHARES = 4,
    parameter int NR       = N_SHARES * (N_SHARES - 1) / 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              en,
    input  logic                              mul,
    input  logic [N_SHARES-1:0][K_WIDTH-1:0]  a,
    input  logic [N_SHARES-1:0][K_WIDTH-1:0]  b,
    input  logic [N_SHARES-1:0][K_WIDTH-1:0]  c,
    input  logic [NR-1:0][K_WIDTH-1:0]        r,
    output logic [N_SHARES-1:0][K_WIDTH-1:0]  q
);

    logic [N_SHARES-1:0][K_WIDTH-1:0] res_q, res_d;

    for (genvar i = 0; i < N_SHARES; i++) begin : g_sh
        logic [N_SHARES-1:0][K_WIDTH-1:0] term;
        logic [K_WIDTH-1:0]               prod;

        // Cross-domain terms are blinded by the word shared with the mirror pair.
        for (genvar j = 0; j < N_SHARES; j++) begin : g_tm
            if (j == i) begin : g_in
                assign term[j] = a[i] & b[i];
            end else if (j > i) begin : g_hi
                localparam int W = pair_idx(i, j, N_SHARES);
                assign term[j] = (a[i] & b[j]) ^ r[W];
            end else begin : g_lo
                localparam int W = pair_idx(j, i, N_SHARES);
                assign term[j] = (a[i] & b[j]) ^ r[W];
            end
        end

        always_comb begin
            prod = '0;
            for (int j = 0; j < N_SHARES; j++) prod = prod ^ term[j];
        end

        assign res_d[i] = en ? (c[i] ^ (mul ? prod : '0)) : res_q[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) res_q <= '0;
        else        res_q <= res_d;
    end

    assign q = res_q;

endmodule

// File: rtl/sec_b2a_iter.sv
// Iterative masked Boolean-to-arithmetic converter: N-1 masked Kogge-Stone
// subtractions of fresh randoms on a shared DOM AND lane pair, then refresh and fold.
module sec_b2a_iter
    import sec_mask_pkg::*;
#(
    parameter int K_WIDTH  = 32,
    parameter int N_SHARES = 4,
    parameter int LOGK     = calc_logk(K_WIDTH),
    parameter int RND_W    = calc_rnd_w(N_SHARES)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ena,
    input  logic                          i_vld,
    output logic                          i_rdy,
    input  logic [K_WIDTH*N_SHARES-1:0]   i_b,
    input  logic [K_WIDTH*RND_W-1:0]      rnd,
    input  logic                          rnd_vld,
    output logic                          rnd_rdy,
    output logic [K_WIDTH*N_SHARES-1:0]   o_a,
    output logic                          o_vld,
    input  logic                          o_rdy
);

    localparam int NR = RND_W / 2;
    localparam int LW = (LOGK > 1) ? $clog2(LOGK) : 1;
    localparam int AW = (N_SHARES > 1) ? $clog2(N_SHARES) : 1;

    typedef logic [N_SHARES-1:0][K_WIDTH-1:0] shares_t;

    state_e        state_q, state_d;
    logic [LW-1:0] lvl_q, lvl_d;
    logic [AW-1:0] add_q, add_d;
    shares_t       z_q, z_d, r_q, r_d, oa_q, oa_d;
    logic          o_vld_q, o_vld_d;

    shares_t b_w, g_q, p_q, y, g_sh, p_sh;
    shares_t g_a, g_b, g_c, p_c;
    logic [RND_W-1:0][K_WIDTH-1:0] rnd_w;
    logic               consume, adv, lane_en, in_lvl;
    logic [K_WIDTH-1:0] zx, rx;

    for (genvar i = 0; i < N_SHARES; i++) begin : g_io
        assign b_w[i] = i_b[share_lo(i, K_WIDTH) +: K_WIDTH];
        assign o_a[share_lo(i, K_WIDTH) +: K_WIDTH] = oa_q[i];
    end

    for (genvar i = 0; i < RND_W; i++) begin : g_rnd
        assign rnd_w[i] = rnd[share_lo(i, K_WIDTH) +: K_WIDTH];
    end

    assign consume = (state_q == ST_LOAD) || (state_q == ST_AND0) ||
                     (state_q == ST_LEVEL) || (state_q == ST_REFRESH);
    // A consuming state with no randomness beat stalls exactly like ena low.
    assign adv     = ena & (~consume | rnd_vld);
    assign rnd_rdy = ena & rnd_vld & consume;
    assign i_rdy   = (state_q == ST_IDLE);
    assign o_vld   = o_vld_q;
    assign in_lvl  = (state_q == ST_LEVEL);
    assign lane_en = adv & ((state_q == ST_AND0) || in_lvl);

    // Operand y is the trivial sharing of -r_j; the level shift is 2^lvl.
    always_comb begin
        y    = '0;
        y[0] = -r_q[add_q];
        for (int i = 0; i < N_SHARES; i++) begin
            g_sh[i] = g_q[i] << (1 << lvl_q);
            p_sh[i] = p_q[i] << (1 << lvl_q);
        end
    end

    assign g_a = in_lvl ? p_q  : z_q;
    assign g_b = in_lvl ? g_sh : y;
    assign g_c = in_lvl ? g_q  : '0;
    assign p_c = in_lvl ? '0   : (z_q ^ y);

    sec_and_dom #(.K_WIDTH(K_WIDTH), .N_SHARES(N_SHARES), .NR(NR)) u_and_g (
        .clk(clk), .rst_n(rst_n), .en(lane_en), .mul(1'b1),
        .a(g_a), .b(g_b), .c(g_c), .r(rnd_w[NR-1:0]), .q(g_q)
    );

    sec_and_dom #(.K_WIDTH(K_WIDTH), .N_SHARES(N_SHARES), .NR(NR)) u_and_p (
        .clk(clk), .rst_n(rst_n), .en(lane_en), .mul(in_lvl),
        .a(p_q), .b(p_sh), .c(p_c), .r(rnd_w[RND_W-1:NR]), .q(p_q)
    );

    always_comb begin
        state_d = state_q;
        lvl_d   = lvl_q;
        add_d   = add_q;
        z_d     = z_q;
        r_d     = r_q;
        oa_d    = oa_q;
        o_vld_d = o_vld_q;
        zx      = '0;
        rx      = '0;
        for (int i = 0; i < N_SHARES; i++) zx = zx ^ z_q[i];
        for (int i = 0; i < N_SHARES - 1; i++) rx = rx ^ rnd_w[i];
        if (adv) begin
            unique case (state_q)
                ST_IDLE: if (i_vld) begin
                    z_d     = b_w;
                    state_d = ST_LOAD;
                end
                ST_LOAD: begin
                    for (int j = 0; j < N_SHARES - 1; j++) r_d[j] = rnd_w[j];
                    add_d   = '0;
                    state_d = ST_AND0;
                end
                ST_AND0: begin
                    lvl_d   = '0;
                    state_d = ST_LEVEL;
                end
                ST_LEVEL: begin
                    if (lvl_q == LW'(LOGK - 1)) state_d = ST_SUM;
                    else                        lvl_d   = lvl_q + LW'(1);
                end
                ST_SUM: begin
                    for (int i = 0; i < N_SHARES; i++) z_d[i] = z_q[i] ^ y[i] ^ (g_q[i] << 1);
                    add_d   = add_q + AW'(1);
                    state_d = (int'(add_q) < N_SHARES - 2) ? ST_AND0 : ST_REFRESH;
                end
                ST_REFRESH: begin
                    for (int i = 0; i < N_SHARES - 1; i++) z_d[i] = z_q[i] ^ rnd_w[i];
                    z_d[N_SHARES-1] = z_q[N_SHARES-1] ^ rx;
                    state_d         = ST_FOLD;
                end
                ST_FOLD: begin
                    oa_d               = r_q;
                    oa_d[N_SHARES-1]   = zx;
                    o_vld_d            = 1'b1;
                    state_d            = ST_DONE;
                end
                ST_DONE: if (o_rdy) begin
                    o_vld_d = 1'b0;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            lvl_q   <= '0;
            add_q   <= '0;
            z_q     <= '0;
            r_q     <= '0;
            oa_q    <= '0;
            o_vld_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lvl_q   <= lvl_d;
            add_q   <= add_d;
            z_q     <= z_d;
            r_q     <= r_d;
            oa_q    <= oa_d;
            o_vld_q <= o_vld_d;
        end
    end

endmodule

// File: tb/tb_sec_b2a_iter.sv
// Directed bench for sec_b2a_iter: exact K=8/N=2 vectors plus K=32/N=4
// sum checks with randomness stalls, enable gaps, output back-pressure and reset.
module tb_sec_b2a_iter;

    typedef struct {
        logic [7:0] b1, b0, w, a1, a0;
    } vec8_t;

    typedef struct {
        logic [31:0] x;
        int          gap;   // 0 none, 1 rnd_vld drop, 2 ena drop
        int          hold;
        int          lat;
    } vec32_t;

    logic clk, rst_n, ena, rnd_vld;
    logic i_vld8, i_rdy8, rnd_rdy8, o_vld8, o_rdy8;
    logic [15:0] ib8, oa8, rnd8;
    logic i_vld32, i_rdy32, rnd_rdy32, o_vld32, o_rdy32;
    logic [127:0] ib32, oa32;
    logic [383:0] rnd32;
    int n_chk, n_err;
    vec8_t  t8[5];
    vec32_t t32[5];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sec_b2a_iter #(.K_WIDTH(8), .N_SHARES(2)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .i_vld(i_vld8), .i_rdy(i_rdy8),
        .i_b(ib8), .rnd(rnd8), .rnd_vld(rnd_vld), .rnd_rdy(rnd_rdy8),
        .o_a(oa8), .o_vld(o_vld8), .o_rdy(o_rdy8)
    );

    sec_b2a_iter #(.K_WIDTH(32), .N_SHARES(4)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .i_vld(i_vld32), .i_rdy(i_rdy32),
        .i_b(ib32), .rnd(rnd32), .rnd_vld(rnd_vld), .rnd_rdy(rnd_rdy32),
        .o_a(oa32), .o_vld(o_vld32), .o_rdy(o_rdy32)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic run8(input vec8_t v);
        int cyc;
        ib8    = {v.b1, v.b0};
        rnd8   = {v.w, v.w};
        i_vld8 = 1'b1;
        @(posedge clk); #1;
        i_vld8 = 1'b0;
        cyc    = 0;
        while (!o_vld8 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("lat8", 128'(cyc), 128'(8));
        chk("oa8", 128'(oa8), 128'({v.a1, v.a0}));
        o_rdy8 = 1'b1;
        @(posedge clk); #1;
        o_rdy8 = 1'b0;
        chk("hs8", 128'({o_vld8, i_rdy8}), 128'(2'b01));
    endtask

    task automatic run32(input vec32_t v);
        logic [31:0]  m0, m1, m2, sum;
        logic [127:0] snap;
        int cyc;
        m0 = $urandom; m1 = $urandom; m2 = $urandom;
        ib32    = {v.x ^ m0 ^ m1 ^ m2, m2, m1, m0};
        i_vld32 = 1'b1;
        @(posedge clk); #1;
        i_vld32 = 1'b0;
        cyc     = 0;
        while (!o_vld32 && cyc < 200) begin
            ena     = !(v.gap == 2 && cyc >= 5 && cyc < 7);
            rnd_vld = !(v.gap == 1 && cyc >= 3 && cyc < 8);
            for (int k = 0; k < 12; k++) rnd32[k*32 +: 32] = $urandom;
            #1;
            if (v.gap == 1 && cyc == 3) chk("gap_rnd_rdy", 128'(rnd_rdy32), 128'(0));
            @(posedge clk); #1;
            cyc++;
        end
        ena     = 1'b1;
        rnd_vld = 1'b1;
        sum = oa32[31:0] + oa32[63:32] + oa32[95:64] + oa32[127:96];
        chk("lat32", 128'(cyc), 128'(v.lat));
        chk("sum32", 128'(sum), 128'(v.x));
        snap = oa32;
        for (int h = 0; h < v.hold; h++) begin
            i_vld32 = 1'b1;
            @(posedge clk); #1;
            chk("hold_oa", oa32, snap);
            chk("hold_vld_rdy", 128'({o_vld32, i_rdy32}), 128'(2'b10));
        end
        i_vld32 = 1'b0;
        o_rdy32 = 1'b1;
        @(posedge clk); #1;
        o_rdy32 = 1'b0;
        chk("hs32", 128'({o_vld32, i_rdy32}), 128'(2'b01));
    endtask

    initial begin
        n_chk = 0; n_err = 0;
        t8[0] = '{8'h99, 8'h3C, 8'h00, 8'hA5, 8'h00};
        t8[1] = '{8'h99, 8'h3C, 8'h5A, 8'h4B, 8'h5A};
        t8[2] = '{8'h00, 8'h00, 8'h01, 8'hFF, 8'h01};
        t8[3] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF};
        t8[4] = '{8'h80, 8'h01, 8'h03, 8'h7E, 8'h03};
        t32[0] = '{32'h00000000, 0, 0, 24};
        t32[1] = '{32'hFFFFFFFF, 0, 0, 24};
        t32[2] = '{32'h12345678, 1, 0, 29};
        t32[3] = '{32'h80000001, 2, 0, 26};
        t32[4] = '{32'hA5A50F0F, 0, 3, 24};

        rst_n = 1'b0; ena = 1'b1; rnd_vld = 1'b1;
        i_vld8 = 1'b0; o_rdy8 = 1'b0; ib8 = '0; rnd8 = '0;
        i_vld32 = 1'b0; o_rdy32 = 1'b0; ib32 = '0; rnd32 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctl8", 128'({o_vld8, i_rdy8, rnd_rdy8}), 128'(3'b010));
        chk("rst_oa8", 128'(oa8), 128'(0));
        chk("rst_ctl32", 128'({o_vld32, i_rdy32, rnd_rdy32}), 128'(3'b010));
        chk("rst_oa32", oa32, 128'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int t = 0; t < 5; t++) run8(t8[t]);
        for (int t = 0; t < 5; t++) run32(t32[t]);

        // Reset pulse mid-operation must drop everything immediately.
        ib32    = {32'h0BADF00D, 32'h1, 32'h2, 32'h3};
        i_vld32 = 1'b1;
        @(posedge clk); #1;
        i_vld32 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ctl", 128'({o_vld32, i_rdy32, rnd_rdy32}), 128'(3'b010));
        chk("rst_mid_oa", oa32, 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run32('{32'hDEADBEEF, 0, 0, 24});

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
